// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter width: must hold values 0..width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// With SERIAL_ADDER_OVF_EN defined the bus also carries the signed-overflow flag ovf.
interface serial_adder_if import serial_adder_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input  busy, done, sum, cout, ovf);
   modport slave  (input  start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input  busy, done, sum, cout);
   modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder used as the serial datapath cell.
module fa_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum_c,
   output logic o_cout_c
);

   assign o_sum_c  = i_a ^ i_b ^ i_cin;
   assign o_cout_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder import serial_adder_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sum;
   logic             w_cout;
   logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   fa_cell u_fa (
      .i_a      (r_a_sh[0]),
      .i_b      (r_b_sh[0]),
      .i_cin    (r_carry),
      .o_sum_c  (w_sum),
      .o_cout_c (w_cout)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // FSM, counter and shift registers share one clocked process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            SHIFT: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_sum   <= (r_sum >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_cout  <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  // r_carry holds the carry into the MSB on the final edge.
                  r_ovf   <= r_carry ^ w_cout;
`endif
                  r_state <= DONE;
               end
            end
            default: begin
               // IDLE and DONE accept a new request identically.
               if (bus.start) begin
                  r_a_sh  <= bus.a;
                  r_b_sh  <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy = (r_state == SHIFT);
   assign bus.done = (r_state == DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule
